// File: rtl/quat_addsub_sequencer.sv
// -----------------------------------------------------------------------------
// quat_addsub_sequencer
//
// Time-multiplexes one external 16-bit adder/subtractor over the four signed
// components of a quaternion add (A+B) or subtract (A-B). Operands come in
// through a valid/ready handshake. The shared adder is then driven with one
// component per cycle, in the order w, x, y, z. Each sum is registered together
// with its signed-overflow flag. The finished 64-bit result is held on a second
// valid/ready handshake until the consumer takes it.
//
// Parameters
//   SATURATE   1: overflowed components clamp to 16'h7FFF / 16'h8000
//              0: overflowed components keep the wrapped two's-complement sum
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   in_valid/ready    operand handshake (ready only while idle)
//   in_a, in_b        operand quaternions packed {z,y,x,w}, w in [15:0]
//   in_op             0 = A+B, 1 = A-B
//   adder_p/q/cin     drive to the shared adder (q is the raw B component;
//                     the adder inverts it itself when cin=1)
//   adder_sum/cout    shared adder result (cout is not needed for signed ovf)
//   out_valid/ready   result handshake
//   out_q, out_ovf    result quaternion and per-component overflow (bit0 = w)
//   busy              an operation is in flight or waiting to be taken
// -----------------------------------------------------------------------------
module quat_addsub_sequencer #(
  parameter bit SATURATE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic        in_op,
  output logic [15:0] adder_p,
  output logic [15:0] adder_q,
  output logic        adder_cin,
  input  logic [15:0] adder_sum,
  input  logic        adder_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_q,
  output logic [3:0]  out_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        idx;
  logic [3:0][15:0]  a_reg;
  logic [3:0][15:0]  b_reg;
  logic              op_reg;
  logic [3:0][15:0]  res_q;

  logic [15:0]       a_comp;
  logic [15:0]       b_comp;
  logic [15:0]       t_comp;
  logic              ovf;
  logic [15:0]       res_comp;

  // Carry-out is meaningless for signed overflow; kept only to tie off the port.
  logic              unused_cout;
  assign unused_cout = adder_cout;

  assign out_q = res_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked assignment is non-blocking so all registers update
  // together from values sampled before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake / adder-port decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    adder_p   = '0;
    adder_q   = '0;
    adder_cin = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        adder_p   = a_comp;
        adder_q   = b_comp;
        adder_cin = op_reg;
        if (idx == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Current component, overflow detection and optional saturation
  // ---------------------------------------------------------------------------
  always_comb begin
    a_comp = a_reg[idx];
    b_comp = b_reg[idx];
    // The effective second operand the adder sees: B for add, ~B for subtract
    // (the +1 arrives via cin and cannot change the sign-based overflow test).
    t_comp = b_comp ^ {16{op_reg}};
    ovf    = (a_comp[15] == t_comp[15]) && (adder_sum[15] != a_comp[15]);
    if (SATURATE && ovf) begin
      res_comp = a_comp[15] ? 16'h8000 : 16'h7FFF;
    end else begin
      res_comp = adder_sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand, index and result registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand and result registers are reset as well, so a reset
  // always leaves zeros on out_q and nothing of an aborted operation behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= 1'b0;
      res_q   <= '0;
      out_ovf <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            op_reg  <= in_op;
            idx     <= '0;
            out_ovf <= '0;
          end
        end
        RUN: begin
          res_q[idx]   <= res_comp;
          out_ovf[idx] <= ovf;
          // Wraps back to 0 after the z component, ready for the next operation.
          idx          <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quat_addsub_sequencer.sv
// -----------------------------------------------------------------------------
// tb_quat_addsub_sequencer
//
// Two instances share all stimulus: one wraps on overflow, one saturates.
// Each instance has its own behavioural model of the shared adder.
// The driver pushes the expected pair of results into a scoreboard queue when an
// operation is accepted. A negedge monitor then checks several things: the adder
// port drive during RUN, the result latency, and the handshake rules. It pops
// and compares the scoreboard on every result handshake.
// -----------------------------------------------------------------------------
module tb_quat_addsub_sequencer;

  localparam int NI = 2;

  typedef struct packed {
    logic [63:0] q;
    logic [3:0]  ovf;
  } res_t;
  typedef res_t [NI-1:0] pair_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_op;
  logic        out_ready;

  logic        in_ready  [NI];
  logic [15:0] adder_p   [NI];
  logic [15:0] adder_q   [NI];
  logic        adder_cin [NI];
  logic [15:0] adder_sum [NI];
  logic        adder_cout[NI];
  logic        out_valid [NI];
  logic [63:0] out_q     [NI];
  logic [3:0]  out_ovf   [NI];
  logic        busy      [NI];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_cyc;
  pair_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quat_addsub_sequencer #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .adder_p(adder_p[0]), .adder_q(adder_q[0]), .adder_cin(adder_cin[0]),
    .adder_sum(adder_sum[0]), .adder_cout(adder_cout[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_q(out_q[0]), .out_ovf(out_ovf[0]), .busy(busy[0])
  );

  quat_addsub_sequencer #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .adder_p(adder_p[1]), .adder_q(adder_q[1]), .adder_cin(adder_cin[1]),
    .adder_sum(adder_sum[1]), .adder_cout(adder_cout[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_q(out_q[1]), .out_ovf(out_ovf[1]), .busy(busy[1])
  );

  // Shared adder: p + (q ^ {16{cin}}) + cin.
  for (genvar g = 0; g < NI; g++) begin : g_adder
    assign {adder_cout[g], adder_sum[g]} = {1'b0, adder_p[g]}
                                         + {1'b0, adder_q[g] ^ {16{adder_cin[g]}}}
                                         + {16'd0, adder_cin[g]};
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain signed integer arithmetic on each component.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic op, input bit sat);
    res_t r;
    logic signed [15:0] ai, bi;
    int s;
    r.q   = '0;
    r.ovf = '0;
    for (int i = 0; i < 4; i++) begin
      ai = a[i*16 +: 16];
      bi = b[i*16 +: 16];
      s  = op ? (int'(ai) - int'(bi)) : (int'(ai) + int'(bi));
      if (s > 32767 || s < -32768) begin
        r.ovf[i] = 1'b1;
        r.q[i*16 +: 16] = sat ? ((s > 0) ? 16'h7FFF : 16'h8000) : s[15:0];
      end else begin
        r.q[i*16 +: 16] = s[15:0];
      end
    end
    return r;
  endfunction

  function automatic pair_t expect_pair(input logic [63:0] a, input logic [63:0] b,
                                        input logic op);
    pair_t p;
    p[0] = model(a, b, op, 1'b0);
    p[1] = model(a, b, op, 1'b1);
    return p;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic op);
    bit accepted = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        accepted = 1'b1;
        acc_cyc  = cyc;
        break;
      end
    end
    check("accept_within_budget", accepted, 1'b1);
    if (accepted) sbq.push_back(expect_pair(a, b, op));
    @(posedge clk); #1;
  endtask

  task automatic drop_valid();
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sbq.size() != 0; n++) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rand_comp();
    unique case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    int          since   = 99;   // cycles since the accepting edge
    bit          pend    = 1'b0;
    bit          prev_hs = 1'b0;
    logic [63:0] pa, pb, cur_a, cur_b;
    logic        pop_l, cur_op;
    pair_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        since   = 99;
        pend    = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (pend) begin
          since  = 0;
          cur_a  = pa;
          cur_b  = pb;
          cur_op = pop_l;
        end else if (since < 99) begin
          since++;
        end
        for (int g = 0; g < NI; g++) begin
          if (since < 4) begin
            check("run_adder_p",  adder_p[g],   cur_a[since*16 +: 16]);
            check("run_adder_q",  adder_q[g],   cur_b[since*16 +: 16]);
            check("run_adder_cin", adder_cin[g], cur_op);
            check("run_flags_busy_inready_outvalid",
                  {busy[g], in_ready[g], out_valid[g]}, 3'b100);
          end else begin
            check("idle_adder_ports", {adder_p[g], adder_q[g], adder_cin[g]}, 33'd0);
          end
          if (since == 4) check("latency_out_valid", out_valid[g], 1'b1);
          if (out_valid[g]) check("in_ready_low_in_done", in_ready[g], 1'b0);
          if (prev_hs) check("out_valid_one_cycle_after_take", out_valid[g], 1'b0);
        end
        prev_hs = 1'b0;
        if (out_valid[0] && out_ready) begin
          check("scoreboard_nonempty", sbq.size() != 0, 1'b1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            for (int g = 0; g < NI; g++) begin
              check("result_valid_both", out_valid[g], 1'b1);
              check("result_q",   out_q[g],   e[g].q);
              check("result_ovf", out_ovf[g], e[g].ovf);
            end
          end
          prev_hs = 1'b1;
        end
        pend  = in_valid && in_ready[0];
        pa    = in_a;
        pb    = in_b;
        pop_l = in_op;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    pair_t       hold;
    logic [63:0] a2, b2;
    int          rel_cyc, prev_acc;
    bit          rnd_on;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("reset_out_q",   out_q[g],   64'd0);
      check("reset_out_ovf", out_ovf[g], 4'd0);
      check("reset_flags_busy_inready_outvalid",
            {busy[g], in_ready[g], out_valid[g]}, 3'b010);
    end
    @(posedge clk); #1;

    // Directed: add, subtract with negatives, overflow in both directions.
    out_ready = 1'b1;
    issue({16'd4, 16'd3, 16'd2, 16'd1}, {16'd40, 16'd30, 16'd20, 16'd10}, 1'b0);
    drop_valid();
    drain();
    issue({16'hFFFB, 16'h0000, 16'h0007, 16'd100},
          {16'd5, 16'hFFFF, 16'd10, 16'hFFE4}, 1'b1);
    drop_valid();
    drain();
    issue({16'h0000, 16'h0000, 16'h8000, 16'h7FFF},
          {16'h0000, 16'h0000, 16'hFFFF, 16'h0001}, 1'b0);
    drop_valid();
    drain();

    // Backpressure: result held in DONE while new operands wait.
    out_ready = 1'b0;
    issue({16'h1234, 16'h8001, 16'h7FF0, 16'h0042},
          {16'h0F00, 16'h0002, 16'h0020, 16'hFFC0}, 1'b1);
    drop_valid();
    hold = expect_pair({16'h1234, 16'h8001, 16'h7FF0, 16'h0042},
                       {16'h0F00, 16'h0002, 16'h0020, 16'hFFC0}, 1'b1);
    wait_out_valid("backpressure_result_arrives");
    a2 = {16'd9, 16'd8, 16'd7, 16'd6};
    b2 = {16'd1, 16'd2, 16'd3, 16'd4};
    fork
      issue(a2, b2, 1'b0);
      begin
        repeat (6) begin
          @(negedge clk);
          for (int g = 0; g < NI; g++) begin
            check("bp_in_ready",  in_ready[g],  1'b0);
            check("bp_out_valid", out_valid[g], 1'b1);
            check("bp_out_q",     out_q[g],     hold[g].q);
            check("bp_out_ovf",   out_ovf[g],   hold[g].ovf);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        rel_cyc = cyc;
      end
    join
    check("bp_accept_cycle_after_release", acc_cyc - rel_cyc, 1);
    drop_valid();
    drain();

    // Reset in RUN with idx=2.
    issue({16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, {16'd1, 16'd1, 16'd1, 16'd1}, 1'b0);
    drop_valid();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("midrst_out_q",   out_q[g],   64'd0);
      check("midrst_out_ovf", out_ovf[g], 4'd0);
      check("midrst_flags_busy_inready_outvalid",
            {busy[g], in_ready[g], out_valid[g]}, 3'b010);
      check("midrst_adder_ports", {adder_p[g], adder_q[g], adder_cin[g]}, 33'd0);
    end
    @(posedge clk); #1;
    issue({16'hFF00, 16'd500, 16'h8000, 16'd3}, {16'h0100, 16'h8000, 16'd1, 16'd3}, 1'b1);
    drop_valid();
    drain();

    // Back-to-back stream with out_ready tied high.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue({rand_comp(), rand_comp(), rand_comp(), rand_comp()},
            {rand_comp(), rand_comp(), rand_comp(), rand_comp()}, k[0]);
      if (k > 0) check("stream_accept_spacing", acc_cyc - prev_acc, 6);
      prev_acc = acc_cyc;
    end
    drop_valid();
    drain();

    // Randomised operands, ops, gaps and backpressure.
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int k = 0; k < 30; k++) begin
      issue({rand_comp(), rand_comp(), rand_comp(), rand_comp()},
            {rand_comp(), rand_comp(), rand_comp(), rand_comp()},
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        drop_valid();
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk); #1;
        end
      end
    end
    drop_valid();
    rnd_on = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
